// File: rtl/hdb3_pkg.sv
// Shared constants for the dual-rail HDB3/AMI line decoder.
package hdb3_pkg;

    // Symbol classes as {p, n} rail pairs
    localparam logic [1:0] SYM_SPACE = 2'b00;
    localparam logic [1:0] SYM_POS   = 2'b10;
    localparam logic [1:0] SYM_NEG   = 2'b01;
    localparam logic [1:0] SYM_ILL   = 2'b11;

    localparam logic MODE_HDB3 = 1'b0;
    localparam logic MODE_AMI  = 1'b1;

    localparam int RUN_LEN_MIN = 3;
    localparam int RUN_LEN_MAX = 8;

endpackage

// File: rtl/hdb3_decoder_sat_counter.sv
// Saturating event counter with a synchronous clear; clear plus event loads 1.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hdb3_decoder.sv
// Dual-rail ternary to NRZ decoder: removes B..V substitution groups in HDB3
// mode, plain AMI otherwise, and counts line-code errors.
module hdb3_decoder
    import hdb3_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_p,
    input  logic             in_n,
    input  logic             mode,
    input  logic             err_clr,
    output logic             out_valid,
    output logic             out_data,
    output logic             v_flag,
    output logic             code_err,
    output logic [CNT_W-1:0] err_cnt
);

    if (RUN_LEN < RUN_LEN_MIN || RUN_LEN > RUN_LEN_MAX) begin : g_bad_run_len
        $error("hdb3_decoder: RUN_LEN out of range");
    end

    logic [RUN_LEN-2:0] sr;
    logic               last_pol;
    logic               have_mark;
    logic               last_vpol;
    logic               have_v;

    logic [1:0] sym;
    logic       is_pos;
    logic       is_mark;
    logic       is_ill;
    logic       same_pol;
    logic       viol;
    logic       err_fill;
    logic       err_vpol;
    logic       err_ami;
    logic       sym_err;

    assign sym     = {in_p, in_n};
    assign is_pos  = (sym == SYM_POS);
    assign is_mark = (sym == SYM_POS) || (sym == SYM_NEG);
    assign is_ill  = (sym == SYM_ILL);

    // A repeated polarity is a violation in HDB3 and a coding error in AMI
    assign same_pol = is_mark && have_mark && (is_pos == last_pol);
    assign viol     = same_pol && (mode == MODE_HDB3);
    assign err_fill = viol && (|sr[RUN_LEN-3:0]);
    assign err_vpol = viol && have_v && (is_pos == last_vpol);
    assign err_ami  = same_pol && (mode == MODE_AMI);
    assign sym_err  = is_ill || err_fill || err_vpol || err_ami;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            v_flag    <= 1'b0;
            code_err  <= 1'b0;
            sr        <= '0;
            last_pol  <= 1'b0;
            have_mark <= 1'b0;
            last_vpol <= 1'b0;
            have_v    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            v_flag    <= in_valid && viol;
            code_err  <= in_valid && sym_err;
            if (in_valid) begin
                if (viol) begin
                    // Drop the whole pending group: B (or leading zero) through V
                    out_data  <= 1'b0;
                    sr        <= '0;
                    last_vpol <= is_pos;
                    have_v    <= 1'b1;
                end else begin
                    out_data <= sr[RUN_LEN-2];
                    sr       <= {sr[RUN_LEN-3:0], is_mark};
                end
                if (is_mark) begin
                    last_pol  <= is_pos;
                    have_mark <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_valid && sym_err),
        .clr   (err_clr),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_hdb3_decoder.sv
// Bench for hdb3_decoder: two instances (RUN_LEN 4 / CNT_W 16 and RUN_LEN 3 / CNT_W 2)
// checked every cycle against a symbol-history model, plus literal expectations.
module tb_hdb3_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, in_p, in_n, mode, err_clr;
    logic ov_a, od_a, vf_a, ce_a;
    logic [15:0] ec_a;
    logic ov_b, od_b, vf_b, ce_b;
    logic [1:0] ec_b;

    hdb3_decoder #(.RUN_LEN(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_p(in_p), .in_n(in_n),
        .mode(mode), .err_clr(err_clr), .out_valid(ov_a), .out_data(od_a),
        .v_flag(vf_a), .code_err(ce_a), .err_cnt(ec_a)
    );

    hdb3_decoder #(.RUN_LEN(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_p(in_p), .in_n(in_n),
        .mode(mode), .err_clr(err_clr), .out_valid(ov_b), .out_data(od_b),
        .v_flag(vf_b), .code_err(ce_b), .err_cnt(ec_b)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: history of decoded bits per symbol since reset; a violation zeroes
    // the last RUN_LEN entries, and each output reads the entry RUN_LEN-1 back.
    bit d[2][0:8191];
    int n_sym[2];
    bit hm[2], lp[2], hv[2], lv[2];
    int cnt[2];
    bit e_ov[2], e_od[2], e_vf[2], e_ce[2];
    bit model_ready = 1'b0;

    always @(posedge clk) begin : model
        int rl, cmax, j;
        bit mark, pol, viol, err;
        for (int i = 0; i < 2; i++) begin
            rl   = (i == 0) ? 4 : 3;
            cmax = (i == 0) ? 65535 : 3;
            err  = 1'b0;
            if (!rst_n) begin
                n_sym[i] = 0; hm[i] = 0; lp[i] = 0; hv[i] = 0; lv[i] = 0; cnt[i] = 0;
                e_ov[i] = 0; e_od[i] = 0; e_vf[i] = 0; e_ce[i] = 0;
            end else begin
                e_ov[i] = in_valid;
                e_vf[i] = 0;
                e_ce[i] = 0;
                if (in_valid) begin
                    j    = n_sym[i];
                    mark = in_p ^ in_n;
                    pol  = in_p;
                    err  = in_p & in_n;
                    viol = (mode == 1'b0) && mark && hm[i] && (pol == lp[i]);
                    if (viol) begin
                        for (int k = 1; k <= rl - 2; k++)
                            if (j - k >= 0 && d[i][j-k]) err = 1'b1;
                        if (hv[i] && lv[i] == pol) err = 1'b1;
                        hv[i] = 1'b1;
                        lv[i] = pol;
                        for (int k = 0; k <= rl - 1; k++)
                            if (j - k >= 0) d[i][j-k] = 1'b0;
                    end else begin
                        d[i][j] = mark;
                    end
                    if (mode == 1'b1 && mark && hm[i] && pol == lp[i]) err = 1'b1;
                    if (mark) begin
                        hm[i] = 1'b1;
                        lp[i] = pol;
                    end
                    e_od[i]  = (j - rl + 1 >= 0) ? d[i][j-rl+1] : 1'b0;
                    e_vf[i]  = viol;
                    e_ce[i]  = err;
                    n_sym[i] = j + 1;
                end
                if (err_clr) cnt[i] = err ? 1 : 0;
                else if (err && cnt[i] < cmax) cnt[i]++;
            end
        end
        model_ready = 1'b1;
    end

    int ov_count = 0;

    always @(negedge clk) begin
        if (ov_a) ov_count++;
        if (model_ready) begin
            check("a_out_valid", ov_a, e_ov[0]);
            check("a_v_flag", vf_a, e_vf[0]);
            check("a_code_err", ce_a, e_ce[0]);
            check("a_err_cnt", ec_a, cnt[0]);
            if (e_ov[0]) check("a_out_data", od_a, e_od[0]);
            check("b_out_valid", ov_b, e_ov[1]);
            check("b_v_flag", vf_b, e_vf[1]);
            check("b_code_err", ce_b, e_ce[1]);
            check("b_err_cnt", ec_b, cnt[1]);
            if (e_ov[1]) check("b_out_data", od_b, e_od[1]);
        end
    end

    task automatic send(input logic p, input logic n);
        in_p = p;
        in_n = n;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        in_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    logic [1:0] pat [13];
    logic [12:0] got_od, got_vf, got_ce;
    logic [6:0] ami_od;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pat = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10,
                2'b00, 2'b00, 2'b00};
        rst_n = 1'b0; in_valid = 1'b0; in_p = 1'b0; in_n = 1'b0; mode = 1'b0; err_clr = 1'b0;
        idle(2);
        rst_n = 1'b1;

        // Partial group, then reset held with the strobe active
        send(1, 0); send(0, 1); send(1, 0);
        rst_n = 1'b0; in_valid = 1'b1; in_p = 1'b1; in_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_out_valid", ov_a, 0);
        check("rst_out_data", od_a, 0);
        check("rst_v_flag", vf_a, 0);
        check("rst_code_err", ce_a, 0);
        check("rst_err_cnt", ec_a, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // HDB3 pattern, continuous strobe
        got_od = '0; got_vf = '0; got_ce = '0;
        for (int i = 0; i < 13; i++) begin
            send(pat[i][1], pat[i][0]);
            got_od = {got_od[11:0], od_a};
            got_vf = {got_vf[11:0], vf_a};
            got_ce = {got_ce[11:0], ce_a};
        end
        check("hdb3_stream", got_od, 13'b0001000000001);
        check("hdb3_vflags", got_vf, 13'b0000100010000);
        check("hdb3_code_err", got_ce, 13'b0);

        // AMI mode
        reset_dut();
        mode = 1'b1;
        ami_od = '0;
        send(1, 0); ami_od = {ami_od[5:0], od_a};
        send(0, 1); ami_od = {ami_od[5:0], od_a};
        send(1, 0); ami_od = {ami_od[5:0], od_a};
        check("ami_no_err_3", ce_a, 0);
        send(1, 0); ami_od = {ami_od[5:0], od_a};
        check("ami_err_4", ce_a, 1);
        check("ami_cnt_4", ec_a, 1);
        check("ami_vflag_4", vf_a, 0);
        for (int i = 0; i < 3; i++) begin
            send(0, 0);
            ami_od = {ami_od[5:0], od_a};
        end
        check("ami_stream", ami_od, 7'b0001111);
        mode = 1'b0;

        // HDB3 coding errors
        reset_dut();
        send(1, 0);
        send(1, 1);
        check("ill_code_err", ce_a, 1);
        send(0, 0); send(0, 0); send(1, 0);
        check("clean_v_flag", vf_a, 1);
        check("clean_v_err", ce_a, 0);
        send(0, 0); send(0, 0); send(1, 0);
        check("vpol_v_flag", vf_a, 1);
        check("vpol_err", ce_a, 1);
        send(0, 1); send(0, 0); send(0, 1);
        check("fill_v_flag", vf_a, 1);
        check("fill_err", ce_a, 1);
        check("err_total", ec_a, 3);

        // Saturation and clear
        reset_dut();
        repeat (5) send(1, 1);
        check("sat_b", ec_b, 3);
        check("nosat_a", ec_a, 5);
        err_clr = 1'b1;
        send(1, 1);
        err_clr = 1'b0;
        check("clr_inc_b", ec_b, 1);
        check("clr_inc_a", ec_a, 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("clr_b", ec_b, 0);

        // Gapped strobe
        reset_dut();
        ov_count = 0;
        got_od = '0;
        for (int i = 0; i < 13; i++) begin
            send(pat[i][1], pat[i][0]);
            got_od = {got_od[11:0], od_a};
            idle($urandom_range(0, 3));
        end
        idle(2);
        check("gap_stream", got_od, 13'b0001000000001);
        check("gap_valid_count", ov_count, 13);

        // Randomised traffic
        reset_dut();
        for (int i = 0; i < 2500; i++) begin
            int r;
            if ($urandom_range(0, 299) == 0) reset_dut();
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            err_clr = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 15);
            if (r == 0) send(1, 1);
            else if (r < 7) send(0, 0);
            else if ($urandom_range(0, 1) == 1) send(1, 0);
            else send(0, 1);
            err_clr = 1'b0;
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
